// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the thresholded FIFO (fifo_umbral) and its storage.
//   DATA_WIDTH_DEF : default data word width in bits
//   ADDR_WIDTH_DEF : default pointer width; depth is 2**ADDR_WIDTH
//   cnt_width()    : width of Count and of the thresholds. It is one bit wider
//                    than the pointers so that both 0 and DEPTH can be held.
//   fifo_flags_t   : the registered status flags, kept together so they are
//                    always updated as one coherent set.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 6;
   localparam int ADDR_WIDTH_DEF = 2;

   // Occupancy runs from 0 to DEPTH inclusive, so it needs one extra bit.
   function automatic int cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
      logic pausa;
   } fifo_flags_t;

endpackage : fifo_pkg

// File: rtl/fifo_umbral_if.sv
// -----------------------------------------------------------------------------
// fifo_umbral_if
// Bundles the producer/consumer side of fifo_umbral.
//
// Handshake:
//   push/pop are single-cycle requests that are sampled on the rising clock
//   edge. A push is taken when the FIFO is not full, or when it is full and a
//   pop is taken in the same cycle. A pop is taken when Count != 0. A rejected
//   request is simply dropped and latches Error_Fifo. Pausa is the
//   back-pressure hint that tells the producer to stop pushing. Fifo_Valid
//   qualifies Fifo_Data_out for exactly one cycle, one cycle after the
//   accepted pop.
//
// Modports:
//   master : producer/consumer side (drives requests, data-in and thresholds)
//   slave  : FIFO side (drives data-out, Count and the flags)
// -----------------------------------------------------------------------------
interface fifo_umbral_if #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH_DEF
);
   import fifo_pkg::*;

   localparam int CW = cnt_width(ADDR_WIDTH);

   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] Fifo_Data_in;
   logic [CW-1:0]         Umbral_AE;
   logic [CW-1:0]         Umbral_AF;

   logic [DATA_WIDTH-1:0] Fifo_Data_out;
   logic                  Fifo_Valid;
   logic [CW-1:0]         Count;
   logic                  Fifo_Empty;
   logic                  Fifo_Full;
   logic                  Almost_Empty;
   logic                  Almost_Full;
   logic                  Pausa;
   logic                  Error_Fifo;

   modport master (
      output push, pop, Fifo_Data_in, Umbral_AE, Umbral_AF,
      input  Fifo_Data_out, Fifo_Valid, Count,
             Fifo_Empty, Fifo_Full, Almost_Empty, Almost_Full, Pausa, Error_Fifo
   );

   modport slave (
      input  push, pop, Fifo_Data_in, Umbral_AE, Umbral_AF,
      output Fifo_Data_out, Fifo_Valid, Count,
             Fifo_Empty, Fifo_Full, Almost_Empty, Almost_Full, Pausa, Error_Fifo
   );

endinterface : fifo_umbral_if

// File: rtl/fifo_umbral_mem.sv
// -----------------------------------------------------------------------------
// dual_port_memory
// Simple dual-port storage: one write port and one read port, with a
// registered read.
//   clk, rst_n : clock and asynchronous active-low reset. The reset clears only
//                the read register; the array itself is never reset.
//   wr_en, wr_addr, wr_data : write port, written on the rising edge
//   rd_en, rd_addr          : read port; rd_data updates on the next edge
//   rd_data                 : registered read data. It holds its value when
//                             rd_en is low.
// A read and a write to the same address in the same cycle return the OLD
// contents. The FIFO depends on this when it is full and pushes and pops at
// the same time.
// -----------------------------------------------------------------------------
module dual_port_memory
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // The array has no reset. The FIFO's empty state makes sure stale words are
   // never read out.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule : dual_port_memory

// File: rtl/fifo_umbral.sv
// -----------------------------------------------------------------------------
// fifo_umbral
// Synchronous FIFO with programmable almost-empty/almost-full thresholds.
//   clk     : single clock, rising edge
//   reset_L : asynchronous, active-low reset
//   bus     : fifo_umbral_if.slave
//             push/pop/Fifo_Data_in  requests and write data
//             Umbral_AE/Umbral_AF    quasi-static thresholds
//             Fifo_Data_out/Valid    read data, valid one cycle after a pop
//             Count                  occupancy, 0..DEPTH
//             Fifo_Empty, Fifo_Full, Almost_Empty, Almost_Full, Pausa,
//             Error_Fifo (sticky until reset)
// Storage is held in dual_port_memory. Pointer, count and flag logic are here.
// All flags are registered from the next-state count, so in any cycle they
// agree with Count.
// -----------------------------------------------------------------------------
module fifo_umbral
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic          clk,
   input  logic          reset_L,
   fifo_umbral_if.slave  bus
);

   localparam int            CW      = cnt_width(ADDR_WIDTH);
   localparam int            DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam fifo_flags_t FLAGS_RESET = '{empty: 1'b1, full: 1'b0,
                                           almost_empty: 1'b0, almost_full: 1'b0,
                                           pausa: 1'b0};

   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   fifo_flags_t           flags_q;
   fifo_flags_t           flags_d;
   logic                  valid_q;
   logic                  error_q;
   logic [DATA_WIDTH-1:0] rd_data;

   logic is_empty;
   logic is_full;
   logic pop_acc;
   logic push_acc;
   logic err_event;

   // ---------------------------------------------------------------------------
   // Acceptance
   // ---------------------------------------------------------------------------
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == DEPTH_C);

   // A pop needs data. A push needs room, or a pop in the same cycle that frees
   // the slot being written.
   assign pop_acc  = bus.pop && !is_empty;
   assign push_acc = bus.push && (!is_full || pop_acc);

   // Errors: any pop while empty (even one paired with a push that is taken),
   // and a push while full that has no accepted pop to make room.
   assign err_event = (bus.pop && is_empty) || (bus.push && is_full && !pop_acc);

   // ---------------------------------------------------------------------------
   // Next-state count and flags
   // ---------------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      flags_d              = FLAGS_RESET;
      flags_d.empty        = (count_d == '0);
      flags_d.full         = (count_d == DEPTH_C);
      flags_d.almost_empty = (count_d <= bus.Umbral_AE) && (count_d != '0);
      flags_d.almost_full  = (count_d >= bus.Umbral_AF) && (count_d != DEPTH_C);
      flags_d.pausa        = flags_d.almost_full || flags_d.full;
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         flags_q  <= FLAGS_RESET;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         // The pointers wrap naturally at DEPTH because they are ADDR_WIDTH bits wide.
         if (push_acc) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
         if (pop_acc)  rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
         count_q <= count_d;
         flags_q <= flags_d;
         valid_q <= pop_acc;
         if (err_event) error_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   dual_port_memory #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (reset_L),
      .wr_en   (push_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.Fifo_Data_in),
      .rd_en   (pop_acc),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.Fifo_Data_out = rd_data;
   assign bus.Fifo_Valid    = valid_q;
   assign bus.Count         = count_q;
   assign bus.Fifo_Empty    = flags_q.empty;
   assign bus.Fifo_Full     = flags_q.full;
   assign bus.Almost_Empty  = flags_q.almost_empty;
   assign bus.Almost_Full   = flags_q.almost_full;
   assign bus.Pausa         = flags_q.pausa;
   assign bus.Error_Fifo    = error_q;

endmodule : fifo_umbral

// File: tb/tb_fifo_umbral.sv
// -----------------------------------------------------------------------------
// tb_fifo_umbral
// Directed self-checking bench for fifo_umbral (DEPTH = 4, 6-bit data,
// Umbral_AE = 1, Umbral_AF = 3).
// -----------------------------------------------------------------------------
module tb_fifo_umbral;

   localparam int DW = 6;
   localparam int AW = 2;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk     = 1'b0;
   logic reset_L = 1'b0;

   always #5 clk = ~clk;

   fifo_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_word;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_status(input string tag, input int cnt,
                               input logic e, input logic f, input logic ae,
                               input logic af, input logic pa, input logic er);
      check({tag, ".count"}, 32'(bus.Count), 32'(cnt));
      check({tag, ".empty"}, 32'(bus.Fifo_Empty), 32'(e));
      check({tag, ".full"},  32'(bus.Fifo_Full), 32'(f));
      check({tag, ".ae"},    32'(bus.Almost_Empty), 32'(ae));
      check({tag, ".af"},    32'(bus.Almost_Full), 32'(af));
      check({tag, ".pausa"}, 32'(bus.Pausa), 32'(pa));
      check({tag, ".err"},   32'(bus.Error_Fifo), 32'(er));
   endtask

   // A read is expected: take the oldest scoreboard word and compare it.
   task automatic check_read(input string tag, input logic vld);
      check({tag, ".valid"}, 32'(bus.Fifo_Valid), 32'(vld));
      if (vld) begin
         if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'(1), 32'(0));
         end else begin
            exp_word = exp_q.pop_front();
            check({tag, ".data"}, 32'(bus.Fifo_Data_out), 32'(exp_word));
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver: one clock cycle of requests, then sample 1 time unit after the edge
   // ---------------------------------------------------------------------------
   task automatic drive(input logic p, input logic q, input logic [DW-1:0] d);
      bus.push         = p;
      bus.pop          = q;
      bus.Fifo_Data_in = d;
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      bus.push         = 1'b0;
      bus.pop          = 1'b0;
      bus.Fifo_Data_in = '0;
      bus.Umbral_AE    = 3'd1;
      bus.Umbral_AF    = 3'd3;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_status("rst", 0, 1, 0, 0, 0, 0, 0);
      check("rst.valid", 32'(bus.Fifo_Valid), 32'(0));
      check("rst.data",  32'(bus.Fifo_Data_out), 32'(0));
      reset_L = 1'b1;
      @(posedge clk);
      #1;

      // Fill with 0x01..0x04; the threshold flags follow Count
      drive(1'b1, 1'b0, 6'h01); exp_q.push_back(6'h01);
      check_status("push1", 1, 0, 0, 1, 0, 0, 0);
      check("push1.valid", 32'(bus.Fifo_Valid), 32'(0));
      drive(1'b1, 1'b0, 6'h02); exp_q.push_back(6'h02);
      check_status("push2", 2, 0, 0, 0, 0, 0, 0);
      drive(1'b1, 1'b0, 6'h03); exp_q.push_back(6'h03);
      check_status("push3", 3, 0, 0, 0, 1, 1, 0);
      drive(1'b1, 1'b0, 6'h04); exp_q.push_back(6'h04);
      check_status("push4", 4, 0, 1, 0, 0, 1, 0);

      // Full: simultaneous push+pop for 6 cycles, across the pointer wrap
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, DW'(6'h05 + i));
         exp_q.push_back(DW'(6'h05 + i));
         check_read($sformatf("wrap%0d", i), 1'b1);
         check_status($sformatf("wrap%0d", i), 4, 0, 1, 0, 0, 1, 0);
      end

      // Push-only while full: the word is dropped and the error latches
      drive(1'b1, 1'b0, 6'h3F);
      check_status("ovf", 4, 0, 1, 0, 0, 1, 1);
      check_read("ovf", 1'b0);

      // Drain: 0x07..0x0A come out in order, never 0x3F
      drive(1'b0, 1'b1, '0);
      check_read("pop1", 1'b1);
      check_status("pop1", 3, 0, 0, 0, 1, 1, 1);
      drive(1'b0, 1'b1, '0);
      check_read("pop2", 1'b1);
      check_status("pop2", 2, 0, 0, 0, 0, 0, 1);
      drive(1'b0, 1'b1, '0);
      check_read("pop3", 1'b1);
      check_status("pop3", 1, 0, 0, 1, 0, 0, 1);
      drive(1'b0, 1'b1, '0);
      check_read("pop4", 1'b1);
      check_status("pop4", 0, 1, 0, 0, 0, 0, 1);

      // Idle: Valid drops and the data output keeps its last value
      drive(1'b0, 1'b0, '0);
      check("idle.valid", 32'(bus.Fifo_Valid), 32'(0));
      check("idle.hold",  32'(bus.Fifo_Data_out), 32'(6'h0A));

      // Pop while empty: rejected, error stays set
      drive(1'b0, 1'b1, '0);
      check_read("udf", 1'b0);
      check_status("udf", 0, 1, 0, 0, 0, 0, 1);

      // Push+pop while empty: the push is taken and the pop is rejected
      drive(1'b1, 1'b1, 6'h11); exp_q.push_back(6'h11);
      check_read("pp_empty", 1'b0);
      check_status("pp_empty", 1, 0, 0, 1, 0, 0, 1);
      drive(1'b0, 1'b1, '0);
      check_read("pp_pop", 1'b1);
      check_status("pp_pop", 0, 1, 0, 0, 0, 0, 1);

      // Two words stored, then an asynchronous reset pulse between clock edges
      drive(1'b1, 1'b0, 6'h12); exp_q.push_back(6'h12);
      drive(1'b1, 1'b0, 6'h13); exp_q.push_back(6'h13);
      check_status("pre_rst", 2, 0, 0, 0, 0, 0, 1);
      #2;
      reset_L = 1'b0;
      #1;
      exp_q.delete();
      check_status("arst", 0, 1, 0, 0, 0, 0, 0);
      check("arst.valid", 32'(bus.Fifo_Valid), 32'(0));
      check("arst.data",  32'(bus.Fifo_Data_out), 32'(0));
      #3;
      reset_L = 1'b1;
      @(posedge clk);
      #1;

      // After reset, the first word pushed is the first word read
      drive(1'b1, 1'b0, 6'h2A); exp_q.push_back(6'h2A);
      check_status("post_push", 1, 0, 0, 1, 0, 0, 0);
      drive(1'b0, 1'b1, '0);
      check_read("post_pop", 1'b1);
      check_status("post_pop", 0, 1, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_fifo_umbral

// File: doc/fifo_umbral.md
FIFO_UMBRAL -- requirements
Module: fifo_umbral

Interface
REQ-001 Parameter DATA_WIDTH, default 6, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 2, pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  reset, asynchronous and active-low.
REQ-005 push  input  1  write request.
REQ-006 pop  input  1  read request.
REQ-007 Fifo_Data_in  input  DATA_WIDTH  write data, sampled with push.
REQ-008 Umbral_AE  input  ADDR_WIDTH+1  almost-empty threshold, quasi-static.
REQ-009 Umbral_AF  input  ADDR_WIDTH+1  almost-full threshold, quasi-static.
REQ-010 Fifo_Data_out  output  DATA_WIDTH  read data.
REQ-011 Fifo_Valid  output  1  Fifo_Data_out holds a popped word this cycle.
REQ-012 Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-013 Fifo_Empty, Fifo_Full, Almost_Empty, Almost_Full, Pausa, Error_Fifo  output  1 each  status flags.

Function
REQ-014 Accepted push (push=1 and not full, or full with accepted pop) writes Fifo_Data_in at wr_ptr and advances wr_ptr by 1, modulo DEPTH.
REQ-015 Accepted pop (pop=1 and Count!=0) reads the entry at rd_ptr and advances rd_ptr by 1, modulo DEPTH.
REQ-016 Read latency is exactly 1 cycle: the word appears on Fifo_Data_out with Fifo_Valid=1 in the cycle after the accepted pop; Fifo_Valid=0 otherwise, and Fifo_Data_out holds its last value.
REQ-017 Count: +1 on push-only, -1 on pop-only, unchanged on simultaneous accepted push and pop; it never exceeds DEPTH and never goes below 0.
REQ-018 Simultaneous push and pop when full: both are accepted, Count stays DEPTH, and no error is raised.
REQ-019 Simultaneous push and pop when empty: the push is accepted, the pop is rejected, Count becomes 1, and Error_Fifo is set.
REQ-020 Push-only when full: the push is dropped, memory and pointers are unchanged, and Error_Fifo is set.
REQ-021 Pop-only when empty: no pointer change, Fifo_Valid=0, and Error_Fifo is set.
REQ-022 Error_Fifo is sticky and clears only on reset.
REQ-023 All flags are registered and computed from the next-state Count, so they are coherent with Count in the same cycle.
REQ-024 Fifo_Empty = (Count==0); Fifo_Full = (Count==DEPTH).
REQ-025 Almost_Empty = (Count<=Umbral_AE) and Count!=0; Almost_Full = (Count>=Umbral_AF) and Count!=DEPTH.
REQ-026 Pausa = Almost_Full or Fifo_Full, as a back-pressure request to the upstream producer.
REQ-027 Pointer wrap from DEPTH-1 to 0 has no effect on data order or flags.

Reset
REQ-028 On reset_L=0, asynchronously: pointers=0, Count=0, Fifo_Empty=1, all other flags=0, Fifo_Valid=0, Fifo_Data_out=0.
REQ-029 Reset asserted mid-operation discards all stored words; the first push after release is the first word read.
REQ-030 Memory array contents are not reset; the empty state guarantees stale data is never output.

Structure
REQ-031 Default DATA_WIDTH, ADDR_WIDTH and the Count/threshold width rule belong in shared package fifo_pkg.
REQ-032 Storage is a single sub-module instance, dual_port_memory, with 1 write and 1 read port and a registered read; pointer, count and flag logic stay in fifo_umbral.

Verification
REQ-033 Reset, then 4 pushes of 0x01..0x04 (DEPTH=4) -> Count 1..4, Fifo_Full=1 after the 4th push, Pausa=1, Error_Fifo=0.
REQ-034 Full, then 4 pops -> 0x01..0x04 out in order, each 1 cycle after its pop with Fifo_Valid=1; Fifo_Empty=1 after the last pop.
REQ-035 Umbral_AE=1, Umbral_AF=3; push 3 words -> Almost_Empty=1 at Count 1, both flags 0 at Count 2, Almost_Full=1 and Pausa=1 at Count 3.
REQ-036 Full with push and pop together, 6 cycles -> Count stays 4, Error_Fifo=0, output order preserved across pointer wrap.
REQ-037 Empty with pop -> Error_Fifo=1 and stays 1; 5th push when full -> word dropped, later reads return only the first 4 words.
REQ-038 reset_L pulsed low asynchronously with 2 words stored -> flags return to reset values immediately; a push of 0x2A then pop returns 0x2A.
